// File: rtl/data_memory_bhw_pkg.sv
// Shared definitions for the RISC-V data memory slice.
//   - funct3 encodings for loads and stores (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - state enumeration of the clear sequencer
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    typedef enum logic {
        ST_INIT,
        ST_READY
    } mem_state_e;

endpackage

// File: rtl/data_memory_bhw_align.sv
// load_store_align: combinational byte-lane steering for RV32I loads/stores.
// Ports:
//   funct3        - access type
//   offset        - byte offset within the word (addr[1:0])
//   wdata         - right-justified store data
//   rword         - word currently stored at the addressed index
//   strobe        - byte-lane write enables
//   wdata_lane    - store data replicated onto the addressed lanes
//   load_data     - selected and sign/zero-extended load value
//   misaligned    - halfword on odd address or word on non-zero offset
//   illegal_load  - funct3 not a valid load encoding
//   illegal_store - funct3 not a valid store encoding
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal_load,
    output logic        illegal_store
);

    // Addressed byte/halfword moved down to bit 0.
    logic [31:0] shifted;
    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        strobe        = 4'b0000;
        wdata_lane    = wdata;
        load_data     = 32'h0;
        misaligned    = 1'b0;
        illegal_load  = 1'b0;
        illegal_store = 1'b0;
        case (funct3)
            F3_B: begin
                strobe     = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                misaligned = offset[0];
                strobe     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                misaligned = (offset != 2'b00);
                strobe     = 4'b1111;
                load_data  = rword;
            end
            F3_BU: begin
                illegal_store = 1'b1;
                load_data     = {24'h0, shifted[7:0]};
            end
            F3_HU: begin
                misaligned    = offset[0];
                illegal_store = 1'b1;
                load_data     = {16'h0, shifted[15:0]};
            end
            default: begin
                illegal_load  = 1'b1;
                illegal_store = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_bhw.sv
// data_memory_bhw: byte-addressable data memory for the MEM stage.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   mem_read      - combinational load request
//   mem_write     - store request, committed on the rising edge
//   funct3        - RV32I load/store width and signedness
//   addr          - little-endian byte address
//   wdata         - right-justified store data
//   rdata         - extended load data (0 when no valid load)
//   busy          - post-reset clear sequence in progress
//   misaligned    - access not naturally aligned
//   access_fault  - address out of range or funct3 illegal for the operation
module data_memory_bhw
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS   = 256,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        misaligned,
    output logic        access_fault
);

    localparam int IDXW = $clog2(DEPTH_WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH_WORDS - 1);
    localparam mem_state_e RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_READY;

    mem_state_e      state_q, state_d;
    logic [IDXW-1:0] clr_ptr_q, clr_ptr_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [IDXW-1:0] word_idx;
    logic [31:0]     rword;
    logic [3:0]      strobe;
    logic [31:0]     wdata_lane;
    logic [31:0]     load_data;
    logic            mis_raw, ill_load, ill_store;
    logic            out_of_range, active, store_en;

    assign word_idx     = addr[IDXW+1:2];
    assign rword        = mem_q[word_idx];
    // Any address bit above the array's span set means out of range; no aliasing.
    assign out_of_range = |(addr >> (IDXW + 2));

    load_store_align u_align (
        .funct3        (funct3),
        .offset        (addr[1:0]),
        .wdata         (wdata),
        .rword         (rword),
        .strobe        (strobe),
        .wdata_lane    (wdata_lane),
        .load_data     (load_data),
        .misaligned    (mis_raw),
        .illegal_load  (ill_load),
        .illegal_store (ill_store)
    );

    assign busy   = (state_q == ST_INIT);
    // Flags only mean something for a live request outside the clear sequence.
    assign active = (mem_read | mem_write) & ~busy;

    assign misaligned   = active & mis_raw;
    assign access_fault = active & (out_of_range | (mem_read & ill_load)
                                                 | (mem_write & ill_store));
    assign rdata    = (mem_read & ~busy & ~misaligned & ~access_fault) ? load_data : 32'h0;
    assign store_en = mem_write & ~busy & ~misaligned & ~access_fault;

    // Clear sequencer: one word per clock, READY after the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: the array has no reset branch; it maps onto plain RAM and is
    // zeroed over DEPTH_WORDS cycles by the sequencer instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_ptr_q] <= 32'h0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bhw.sv
// Self-checking bench for data_memory_bhw (DEPTH_WORDS = 16).
// Stimulus pushes expected responses into a scoreboard queue; a monitor
// samples the DUT on the falling edge and compares.
module tb_data_memory_bhw;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, misaligned, access_fault;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    logic chk_req = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_bhw #(.DEPTH_WORDS(16), .INIT_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy         (busy),
        .misaligned   (misaligned),
        .access_fault (access_fault)
    );

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (chk_req) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: no expectation queued");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rdata !== e.rdata || misaligned !== e.mis ||
                    access_fault !== e.fault || busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h mis=%b fault=%b busy=%b, expected rdata=%h mis=%b fault=%b busy=%b",
                             e.name, rdata, misaligned, access_fault, busy,
                             e.rdata, e.mis, e.fault, e.busy);
                end
            end
        end
    end

    // Drive one request for one clock (called just after a rising edge).
    task automatic op(input string nm, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis,
                      input logic exp_fault, input logic exp_busy);
        exp_t e;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        e.name  = nm;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.fault = exp_fault;
        e.busy  = exp_busy;
        sb_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Count edges until busy falls, starting from n_start edges already seen.
    task automatic count_busy(input string nm, input int n_start);
        int n;
        n = n_start;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b010; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
        // Reset state: busy high, everything else gated to 0.
        op("reset_state", 1, 0, 3'b010, 32'h2, 0, 32'h0, 0, 0, 1);
        rst = 1'b0;
        count_busy("busy_edges_after_reset", 0);

        op("lw_3c_cleared", 1, 0, 3'b010, 32'h3C, 0, 32'h0, 0, 0, 0);

        // Sign and zero extension.
        op("sw_8",   0, 1, 3'b010, 32'h8, 32'h8899AABB, 32'h0, 0, 0, 0);
        op("lb_9",   1, 0, 3'b000, 32'h9, 0, 32'hFFFFFFAA, 0, 0, 0);
        op("lbu_9",  1, 0, 3'b100, 32'h9, 0, 32'h000000AA, 0, 0, 0);
        op("lh_a",   1, 0, 3'b001, 32'hA, 0, 32'hFFFF8899, 0, 0, 0);
        op("lhu_a",  1, 0, 3'b101, 32'hA, 0, 32'h00008899, 0, 0, 0);
        op("lw_8",   1, 0, 3'b010, 32'h8, 0, 32'h8899AABB, 0, 0, 0);

        // Byte lanes.
        op("sb_d",     0, 1, 3'b000, 32'hD, 32'h12345677, 32'h0, 0, 0, 0);
        op("lw_c_sb",  1, 0, 3'b010, 32'hC, 0, 32'h00007700, 0, 0, 0);
        op("sh_e",     0, 1, 3'b001, 32'hE, 32'h0000CAFE, 32'h0, 0, 0, 0);
        op("lw_c_sh",  1, 0, 3'b010, 32'hC, 0, 32'hCAFE7700, 0, 0, 0);

        // Misalignment.
        op("sw_4",        0, 1, 3'b010, 32'h4, 32'h11223344, 32'h0, 0, 0, 0);
        op("sh_5_mis",    0, 1, 3'b001, 32'h5, 32'h0000FFFF, 32'h0, 1, 0, 0);
        op("lw_4_kept",   1, 0, 3'b010, 32'h4, 0, 32'h11223344, 0, 0, 0);
        op("lw_2_mis",    1, 0, 3'b010, 32'h2, 0, 32'h0, 1, 0, 0);
        op("lhu_3_mis",   1, 0, 3'b101, 32'h3, 0, 32'h0, 1, 0, 0);
        op("sh_6",        0, 1, 3'b001, 32'h6, 32'h0000BEEF, 32'h0, 0, 0, 0);
        op("lw_4_sh6",    1, 0, 3'b010, 32'h4, 0, 32'hBEEF3344, 0, 0, 0);

        // Range and illegal funct3.
        op("sw_40_oor",   0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 0, 1, 0);
        op("lw_0_clean",  1, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 0);
        op("lw_40_oor",   1, 0, 3'b010, 32'h40, 0, 32'h0, 0, 1, 0);
        op("s_f3_100",    0, 1, 3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 0, 1, 0);
        op("lw_0_nowr",   1, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 0);
        op("l_f3_011",    1, 0, 3'b011, 32'h0, 0, 32'h0, 0, 1, 0);
        op("idle_flags",  0, 0, 3'b010, 32'h41, 0, 32'h0, 0, 0, 0);

        // Top word boundary.
        op("sw_3c",       0, 1, 3'b010, 32'h3C, 32'h80017FFF, 32'h0, 0, 0, 0);
        op("lh_3e",       1, 0, 3'b001, 32'h3E, 0, 32'hFFFF8001, 0, 0, 0);
        op("lhu_3c",      1, 0, 3'b101, 32'h3C, 0, 32'h00007FFF, 0, 0, 0);
        op("lb_3f",       1, 0, 3'b000, 32'h3F, 0, 32'hFFFFFF80, 0, 0, 0);

        // Read and write of the same word in one cycle.
        op("sw_10",       0, 1, 3'b010, 32'h10, 32'hA5A5A5A5, 32'h0, 0, 0, 0);
        op("rw_10_old",   1, 1, 3'b010, 32'h10, 32'h5A5A5A5A, 32'hA5A5A5A5, 0, 0, 0);
        op("lw_10_new",   1, 0, 3'b010, 32'h10, 0, 32'h5A5A5A5A, 0, 0, 0);

        // Reset during INIT, with a store attempted while busy.
        op("sw_0",        0, 1, 3'b010, 32'h0, 32'h12345678, 32'h0, 0, 0, 0);
        op("lw_0_set",    1, 0, 3'b010, 32'h0, 0, 32'h12345678, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op("sw_0_busy",   1, 1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        count_busy("busy_edges_after_abort", 1);
        op("lw_0_after",  1, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 0);
        op("lw_10_after", 1, 0, 3'b010, 32'h10, 0, 32'h0, 0, 0, 0);

        @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
